extra_slot_arbiter: RTL and testbench

- Owns the third bus cycle of the 4-cycle interleave (busCycle == 2'b10), the "extra" memory slot.
- Shares that slot on demand between internal floppy DMA, external floppy DMA and the sound fetch.
- Replaces the fixed three-way slot rotation. Idle requesters no longer consume slots.
- Sound gets a bounded worst-case latency, so the audio stream can never be starved.

---
 rtl/extra_slot_arbiter.sv | 118 +++++++++++
 tb/tb_extra_slot_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/extra_slot_arbiter.sv
// rtl/extra_slot_arbiter.sv - on-demand arbiter for the extra (busCycle 10) memory slot
// Optional statistics counters enabled by EXTRA_SLOT_ARB_STATS_EN.
module extra_slot_arbiter #(
  parameter int unsigned SND_PERIOD   = 4,
  parameter logic [21:0] DSK_INT_BASE = 22'h100000,
  parameter logic [21:0] DSK_EXT_BASE = 22'h200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk8_en_p,
  input  logic [1:0]  busCycle,
  input  logic        req_dsk_int,
  input  logic [21:0] dsk_int_addr,
  input  logic        req_dsk_ext,
  input  logic [21:0] dsk_ext_addr,
  input  logic        req_snd,
  input  logic [21:0] snd_addr,
  output logic        ack_dsk_int,
  output logic        ack_dsk_ext,
  output logic        ack_snd,
  output logic [21:0] slot_addr,
  output logic        slot_rom_oe,
  output logic        slot_ram_oe,
  output logic [15:0] stat_snd_grants,
  output logic [15:0] stat_idle_slots
);

  localparam logic [3:0] WAIT_MAX = 4'(SND_PERIOD - 1);

  logic [2:0] grant, grant_nxt;
  logic [1:0] rr_ptr, rr_nxt;
  logic [3:0] snd_wait, wait_nxt;
  logic       decide, release_slot, in_slot;

  assign decide       = clk8_en_p && (busCycle == 2'b01);
  assign release_slot = clk8_en_p && (busCycle == 2'b10);
  assign in_slot      = (busCycle == 2'b10);

  // rr_ptr holds the last disk granted (0 = internal, 1 = external)
  always_comb begin
    grant_nxt = 3'b000;
    rr_nxt    = rr_ptr;
    if (req_snd && (snd_wait == WAIT_MAX)) begin
      grant_nxt = 3'b100;
    end else if (req_dsk_int && req_dsk_ext) begin
      if (rr_ptr == 2'd1) begin
        grant_nxt = 3'b001;
        rr_nxt    = 2'd0;
      end else begin
        grant_nxt = 3'b010;
        rr_nxt    = 2'd1;
      end
    end else if (req_dsk_int) begin
      grant_nxt = 3'b001;
      rr_nxt    = 2'd0;
    end else if (req_dsk_ext) begin
      grant_nxt = 3'b010;
      rr_nxt    = 2'd1;
    end else if (req_snd) begin
      grant_nxt = 3'b100;
    end

    wait_nxt = snd_wait;
    if (grant_nxt[2] || !req_snd)
      wait_nxt = 4'd0;
    else if (snd_wait != WAIT_MAX)
      wait_nxt = snd_wait + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant    <= 3'b000;
      rr_ptr   <= 2'd1;
      snd_wait <= 4'd0;
    end else if (decide) begin
      grant    <= grant_nxt;
      rr_ptr   <= rr_nxt;
      snd_wait <= wait_nxt;
    end else if (release_slot) begin
      grant    <= 3'b000;
    end
  end

  assign ack_dsk_int = grant[0] && in_slot;
  assign ack_dsk_ext = grant[1] && in_slot;
  assign ack_snd     = grant[2] && in_slot;
  assign slot_rom_oe = ack_dsk_int | ack_dsk_ext;
  assign slot_ram_oe = ack_snd;

  // Addresses pass through live; the base add wraps at 22 bits
  always_comb begin
    slot_addr = 22'd0;
    if (ack_dsk_int)
      slot_addr = dsk_int_addr + DSK_INT_BASE;
    else if (ack_dsk_ext)
      slot_addr = dsk_ext_addr + DSK_EXT_BASE;
    else if (ack_snd)
      slot_addr = snd_addr;
  end

`ifdef EXTRA_SLOT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_snd_grants <= 16'd0;
      stat_idle_slots <= 16'd0;
    end else if (decide) begin
      if (grant_nxt[2] && (stat_snd_grants != 16'hFFFF))
        stat_snd_grants <= stat_snd_grants + 16'd1;
      if ((grant_nxt == 3'b000) && (stat_idle_slots != 16'hFFFF))
        stat_idle_slots <= stat_idle_slots + 16'd1;
    end
  end
`else
  assign stat_snd_grants = 16'd0;
  assign stat_idle_slots = 16'd0;
`endif

endmodule

// File: tb/tb_extra_slot_arbiter.sv
// tb/tb_extra_slot_arbiter.sv - randomized self-checking bench for extra_slot_arbiter
module tb_extra_slot_arbiter;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk8_en_p = 1'b0;
  logic [1:0]  busCycle = 2'b00;
  logic        req_dsk_int = 1'b0, req_dsk_ext = 1'b0, req_snd = 1'b0;
  logic [21:0] dsk_int_addr = '0, dsk_ext_addr = '0, snd_addr = '0;
  logic        ack_dsk_int, ack_dsk_ext, ack_snd, slot_rom_oe, slot_ram_oe;
  logic [21:0] slot_addr;
  logic [15:0] stat_snd_grants, stat_idle_slots;
  logic [2:0]  ackv;

  int n_pass = 0, n_total = 0;
  int phase = 0;
  int clk_cnt = 0;

  // Reference model: the arbiter seen as a per-slot decision
  bit m_last_ext;
  int m_denied;
  int m_snd_grants, m_idle;

  extra_slot_arbiter #(.SND_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .clk8_en_p(clk8_en_p), .busCycle(busCycle),
    .req_dsk_int(req_dsk_int), .dsk_int_addr(dsk_int_addr),
    .req_dsk_ext(req_dsk_ext), .dsk_ext_addr(dsk_ext_addr),
    .req_snd(req_snd), .snd_addr(snd_addr),
    .ack_dsk_int(ack_dsk_int), .ack_dsk_ext(ack_dsk_ext), .ack_snd(ack_snd),
    .slot_addr(slot_addr), .slot_rom_oe(slot_rom_oe), .slot_ram_oe(slot_ram_oe),
    .stat_snd_grants(stat_snd_grants), .stat_idle_slots(stat_idle_slots)
  );

  assign ackv = {ack_snd, ack_dsk_ext, ack_dsk_int};

  always #5 clk = ~clk;

  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (clk8_en_p) busCycle = busCycle + 2'd1;
      phase = (phase + 1) % 4;
      clk8_en_p = (phase == 3);
    end
  end

  // Acks are one-hot and only present in the extra cycle
  always @(negedge clk) begin
    if (!reset) begin
      n_total++;
      if ($countones(ackv) > 1 || (busCycle != 2'b10 && ackv != 3'b000))
        $display("FAIL ack_invariant: acks=%b busCycle=%b required one-hot inside 10 only", ackv, busCycle);
      else
        n_pass++;
    end
  end

  function automatic int model_pick(bit ri, bit re, bit rs);
    if (rs && m_denied >= P - 1) return 3;
    if (ri && re) return m_last_ext ? 1 : 2;
    if (ri) return 1;
    if (re) return 2;
    if (rs) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_last_ext   = 1'b1;
    m_denied     = 0;
    m_snd_grants = 0;
    m_idle       = 0;
  endtask

  task automatic do_reset();
    req_dsk_int = 0; req_dsk_ext = 0; req_snd = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_decision(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (clk8_en_p && busCycle == 2'b01) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL decision_timeout: no decision point within 24 clocks, required one");
    end
  endtask

  // Runs one slot; returns expected one-hot grant/address and observed outputs
  task automatic run_slot(output logic [2:0] exp_ack, output logic [21:0] exp_addr,
                          output logic [2:0] obs_ack, output logic [21:0] obs_addr,
                          output logic obs_rom, output logic obs_ram);
    bit ok;
    int pick;
    wait_decision(ok);
    pick = model_pick(req_dsk_int, req_dsk_ext, req_snd);
    case (pick)
      1: begin exp_ack = 3'b001; exp_addr = dsk_int_addr + 22'h100000; m_last_ext = 0; end
      2: begin exp_ack = 3'b010; exp_addr = dsk_ext_addr + 22'h200000; m_last_ext = 1; end
      3: begin exp_ack = 3'b100; exp_addr = snd_addr; m_snd_grants++; end
      default: begin exp_ack = 3'b000; exp_addr = 22'd0; m_idle++; end
    endcase
    if (pick == 3 || !req_snd) m_denied = 0;
    else if (m_denied < P - 1) m_denied++;
    @(posedge clk);
    @(negedge clk);
    obs_ack  = ackv;
    obs_addr = slot_addr;
    obs_rom  = slot_rom_oe;
    obs_ram  = slot_ram_oe;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_total++;
    if ({ackv, slot_addr, slot_rom_oe, slot_ram_oe} !== 27'd0)
      $display("FAIL reset_outputs: acks=%b addr=%h rom=%b ram=%b required all 0", ackv, slot_addr, slot_rom_oe, slot_ram_oe);
    else n_pass++;
    n_total++;
    if ({stat_snd_grants, stat_idle_slots} !== 32'd0)
      $display("FAIL reset_stats: snd=%0d idle=%0d required 0/0", stat_snd_grants, stat_idle_slots);
    else n_pass++;
  endtask

  task automatic test_single_int();
    logic [2:0] ea, oa; logic [21:0] ed, od; logic rom, ram;
    do_reset();
    req_dsk_int = 1; dsk_int_addr = 22'h000ABC;
    for (int s = 0; s < 4; s++) begin
      run_slot(ea, ed, oa, od, rom, ram);
      n_total++;
      if (oa !== 3'b001 || od !== 22'h100ABC || rom !== 1'b1 || ram !== 1'b0)
        $display("FAIL single_int slot%0d: acks=%b addr=%h rom=%b ram=%b required 001/100abc/1/0", s, oa, od, rom, ram);
      else n_pass++;
    end
  endtask

  task automatic test_two_disks();
    logic [2:0] ea, oa; logic [21:0] ed, od; logic rom, ram;
    logic [2:0] fixed_exp;
    do_reset();
    req_dsk_int = 1; req_dsk_ext = 1;
    dsk_int_addr = 22'h000ABC; dsk_ext_addr = 22'h000010;
    for (int s = 0; s < 6; s++) begin
      run_slot(ea, ed, oa, od, rom, ram);
      fixed_exp = (s % 2 == 0) ? 3'b001 : 3'b010;
      n_total++;
      if (oa !== fixed_exp || od !== ((s % 2 == 0) ? 22'h100ABC : 22'h200010) || rom !== 1'b1)
        $display("FAIL two_disks slot%0d: acks=%b addr=%h rom=%b required %b", s, oa, od, rom, fixed_exp);
      else n_pass++;
    end
  endtask

  task automatic test_all_three();
    logic [2:0] ea, oa; logic [21:0] ed, od; logic rom, ram;
    logic [2:0] pattern [8];
    int streak, worst;
    pattern = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100};
    do_reset();
    req_dsk_int = 1; req_dsk_ext = 1; req_snd = 1;
    snd_addr = 22'h0355AA;
    streak = 0; worst = 0;
    for (int s = 0; s < 16; s++) begin
      run_slot(ea, ed, oa, od, rom, ram);
      if (oa == 3'b100) streak = 0; else streak++;
      if (streak > worst) worst = streak;
      n_total++;
      if (oa !== pattern[s % 8] || od !== ed || ram !== (pattern[s % 8] == 3'b100))
        $display("FAIL all_three slot%0d: acks=%b addr=%h ram=%b required %b addr=%h", s, oa, od, ram, pattern[s % 8], ed);
      else n_pass++;
    end
    n_total++;
    if (worst > P - 1) $display("FAIL snd_latency: worst denial streak %0d required <= %0d", worst, P - 1);
    else n_pass++;
    n_total++;
`ifdef EXTRA_SLOT_ARB_STATS_EN
    if (stat_snd_grants !== 16'(m_snd_grants))
      $display("FAIL stat_snd_grants: got %0d required %0d", stat_snd_grants, m_snd_grants);
`else
    if (stat_snd_grants !== 16'd0)
      $display("FAIL stat_snd_grants: got %0d required 0", stat_snd_grants);
`endif
    else n_pass++;
  endtask

  task automatic test_idle();
    logic [2:0] ea, oa; logic [21:0] ed, od; logic rom, ram;
    int bad;
    do_reset();
    bad = 0;
    for (int s = 0; s < 10; s++) begin
      run_slot(ea, ed, oa, od, rom, ram);
      if (oa !== 3'b000 || od !== 22'd0 || rom !== 1'b0 || ram !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_slots: %0d slots had acks/address, required 0", bad);
    else n_pass++;
    n_total++;
`ifdef EXTRA_SLOT_ARB_STATS_EN
    if (stat_idle_slots !== 16'd10) $display("FAIL stat_idle_slots: got %0d required 10", stat_idle_slots);
`else
    if (stat_idle_slots !== 16'd0) $display("FAIL stat_idle_slots: got %0d required 0", stat_idle_slots);
`endif
    else n_pass++;
  endtask

  task automatic test_reset_mid_slot();
    logic [2:0] ea, oa; logic [21:0] ed, od; logic rom, ram;
    do_reset();
    req_snd = 1; snd_addr = 22'h012345;
    run_slot(ea, ed, oa, od, rom, ram);
    n_total++;
    if (oa !== 3'b100 || od !== 22'h012345) $display("FAIL mid_reset_pre: acks=%b addr=%h required 100/012345", oa, od);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_total++;
    if (ack_snd !== 1'b0 || slot_ram_oe !== 1'b0 || busCycle !== 2'b10)
      $display("FAIL mid_reset_ack: ack_snd=%b ram=%b bus=%b required 0/0 in 10", ack_snd, slot_ram_oe, busCycle);
    else n_pass++;
    reset = 1'b0;
    model_reset();
    req_snd = 0; req_dsk_ext = 1; dsk_ext_addr = 22'h3FFFFF;
    run_slot(ea, ed, oa, od, rom, ram);
    n_total++;
    if (oa !== 3'b010 || od !== 22'h1FFFFF) $display("FAIL mid_reset_post: acks=%b addr=%h required 010/1fffff", oa, od);
    else n_pass++;
  endtask

  task automatic test_late_request();
    int t0, lat;
    bit seen_early, got;
    do_reset();
    for (int i = 0; i < 24 && busCycle != 2'b10; i++) @(negedge clk);
    req_dsk_int = 1; dsk_int_addr = 22'h000001;
    t0 = clk_cnt;
    seen_early = 0;
    while (busCycle == 2'b10) begin
      if (ackv != 3'b000) seen_early = 1;
      @(negedge clk);
    end
    got = 0;
    for (int i = 0; i < 24; i++) begin
      if (ack_dsk_int) begin got = 1; break; end
      @(negedge clk);
    end
    lat = (clk_cnt - t0 + 3) / 4;
    n_total++;
    if (seen_early || !got || lat < 1 || lat > 4)
      $display("FAIL late_request: early=%b got=%b latency=%0d clk8 required no early ack, 1..4", seen_early, got, lat);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] ea, oa; logic [21:0] ed, od; logic rom, ram;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      {req_snd, req_dsk_ext, req_dsk_int} = 3'($urandom_range(0, 7));
      dsk_int_addr = 22'($urandom); dsk_ext_addr = 22'($urandom); snd_addr = 22'($urandom);
      run_slot(ea, ed, oa, od, rom, ram);
      n_total++;
      if (oa !== ea || od !== ed || rom !== (ea[0] | ea[1]) || ram !== ea[2])
        $display("FAIL random slot%0d: acks=%b addr=%h rom=%b ram=%b required %b addr=%h", s, oa, od, rom, ram, ea, ed);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_int();
    test_two_disks();
    test_all_three();
    test_idle();
    test_reset_mid_slot();
    test_late_request();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
